// File: rtl/stepper_quadrant_drive.sv
// Full-step unipolar stepper driver that walks the rotor one quadrant at a time
// toward the requested quadrant, settling after each quadrant before re-deciding.
module stepper_quadrant_drive #(
  parameter int STEPS_PER_QUARTER = 50,
  parameter int STEP_DIV          = 50000,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] desiredPosition,
  output logic [1:0] physicalPosition,
  output logic [3:0] coil,
  output logic       busy,
  output logic       dirCw,
  output logic       arrive
);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEPS_PER_QUARTER - 1);

  state_t           state_q;
  logic [1:0]       pos_q;
  logic [1:0]       phase_q;
  logic [3:0]       coil_q;
  logic             dir_q;
  logic             arrive_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] step_q;

  logic [1:0] diff;
  logic [1:0] phase_nx;

  // Shortest-path decision: a half-turn tie resolves clockwise.
  assign diff     = desiredPosition - pos_q;
  assign phase_nx = dir_q ? (phase_q + 2'd1) : (phase_q - 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= 2'd0;
      phase_q  <= 2'd0;
      coil_q   <= 4'b0001;
      dir_q    <= 1'b1;
      arrive_q <= 1'b0;
      div_q    <= '0;
      step_q   <= '0;
    end else begin
      arrive_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (diff != 2'd0) begin
            state_q <= MOVE;
            dir_q   <= (diff != 2'd3);
            div_q   <= '0;
            step_q  <= '0;
          end
        end
        MOVE: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            phase_q <= phase_nx;
            coil_q  <= 4'b0001 << phase_nx;
            if (step_q == STEP_LAST) begin
              step_q  <= '0;
              pos_q   <= dir_q ? (pos_q + 2'd1) : (pos_q - 2'd1);
              state_q <= SETTLE;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        SETTLE: begin
          if (div_q == DIV_LAST) begin
            div_q  <= '0;
            step_q <= '0;
            if (diff != 2'd0) begin
              state_q <= MOVE;
              dir_q   <= (diff != 2'd3);
            end else begin
              state_q  <= IDLE;
              arrive_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign physicalPosition = pos_q;
  assign coil             = coil_q;
  assign dirCw            = dir_q;
  assign arrive           = arrive_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_stepper_quadrant_drive.sv
// Directed plus randomized stimulus against a timeline model of quadrant moves.
`timescale 1ns/1ps
module tb_stepper_quadrant_drive;

  localparam int SPQ = 3;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] des = 2'd0;
  logic [1:0] pos;
  logic [3:0] coil;
  logic       busy;
  logic       dirCw;
  logic       arrive;

  always #5 clk = ~clk;

  stepper_quadrant_drive #(
    .STEPS_PER_QUARTER(SPQ),
    .STEP_DIV(DIV),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .desiredPosition(des),
    .physicalPosition(pos),
    .coil(coil),
    .busy(busy),
    .dirCw(dirCw),
    .arrive(arrive)
  );

  int total = 0;
  int bad = 0;

  // Model: a move is a timeline measured in cycles since MOVE entry.
  int m_pos = 0, m_phase = 0, m_base = 0, m_el = 0;
  bit m_busy = 1'b0, m_dir = 1'b1, m_arrive = 1'b0;
  int dut_arrives = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_phase = 0; m_base = 0; m_el = 0;
    m_busy = 1'b0; m_dir = 1'b1; m_arrive = 1'b0;
  endtask

  task automatic model_start(input int d);
    m_busy = 1'b1;
    m_dir  = (d != 3);
    m_el   = 0;
    m_base = m_phase;
  endtask

  task automatic model_edge();
    int d, s;
    m_arrive = 1'b0;
    d = (int'(des) - m_pos + 4) % 4;
    if (!m_busy) begin
      if (d != 0) model_start(d);
    end else begin
      m_el++;
      s = m_el / DIV;
      if (s > SPQ) s = SPQ;
      m_phase = m_dir ? (m_base + s) % 4 : (m_base + 4 - (s % 4)) % 4;
      if (m_el == SPQ * DIV) m_pos = (m_pos + (m_dir ? 1 : 3)) % 4;
      if (m_el == (SPQ + 1) * DIV) begin
        d = (int'(des) - m_pos + 4) % 4;
        if (d != 0) model_start(d);
        else begin
          m_busy = 1'b0;
          m_arrive = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("pos",    16'(pos),    16'(m_pos));
    chk("coil",   16'(coil),   16'(4'b0001 << m_phase));
    chk("busy",   16'(busy),   16'(m_busy));
    chk("dirCw",  16'(dirCw),  16'(m_dir));
    chk("arrive", 16'(arrive), 16'(m_arrive));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    if (arrive === 1'b1) dut_arrives++;
    check_all();
  endtask

  task automatic run_idle(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (m_busy && n < maxc);
    chk({tag, "_idle"}, 16'(busy), 16'd0);
  endtask

  initial begin
    int edges;
    int rc;

    // 1: reset, then hold at quadrant 0
    rst = 1'b1;
    des = 2'd0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    dut_arrives = 0;
    repeat (20) cycle();
    chk("idle_no_arrive", 16'(dut_arrives), 16'd0);
    $display("step1: reset hold pos=%0d coil=%b busy=%0d", pos, coil, busy);

    // 2: 00 -> 01, arrive on the 17th edge after the request is visible
    des = 2'd1;
    dut_arrives = 0;
    edges = 0;
    for (int i = 0; i < 40 && dut_arrives == 0; i++) begin
      cycle();
      edges++;
    end
    chk("arrive_latency", 16'(edges), 16'((SPQ + 1) * DIV + 1));
    chk("one_quadrant_pos", 16'(pos), 16'd1);
    $display("step2: 00->01 edges=%0d pos=%0d", edges, pos);

    // 3: back to 00, then 00 -> 11 ccw wrap, then 11 -> 00 cw wrap
    des = 2'd0;
    run_idle("back00", 100);
    des = 2'd3;
    run_idle("to11", 100);
    chk("wrap_ccw", 16'(pos), 16'd3);
    des = 2'd0;
    run_idle("to00", 100);
    chk("wrap_cw", 16'(pos), 16'd0);
    $display("step3: wraps done pos=%0d", pos);

    // 4: half-turn tie goes cw, two quadrants back-to-back, single arrive
    des = 2'd2;
    dut_arrives = 0;
    run_idle("half", 200);
    chk("half_pos", 16'(pos), 16'd2);
    chk("half_dir", 16'(dirCw), 16'd1);
    chk("half_arrives", 16'(dut_arrives), 16'd1);
    $display("step4: half turn pos=%0d arrives=%0d", pos, dut_arrives);

    // 5: retarget mid-quadrant; current quadrant still completes
    des = 2'd0;
    run_idle("back00b", 200);
    des = 2'd1;
    dut_arrives = 0;
    repeat (6) cycle();
    des = 2'd3;
    run_idle("retarget", 300);
    chk("retarget_pos", 16'(pos), 16'd3);
    chk("retarget_arrives", 16'(dut_arrives), 16'd1);
    $display("step5: retarget pos=%0d arrives=%0d", pos, dut_arrives);

    // 6: asynchronous reset between edges mid-move
    des = 2'd1;
    repeat (7) cycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    des = 2'd0;
    rst = 1'b0;
    dut_arrives = 0;
    repeat (10) cycle();
    chk("post_reset_arrives", 16'(dut_arrives), 16'd0);
    $display("step6: async reset pos=%0d busy=%0d", pos, busy);

    // Randomized retargeting
    for (int k = 0; k < 40; k++) begin
      des = 2'($urandom_range(0, 3));
      rc = $urandom_range(1, 30);
      repeat (rc) cycle();
      $display("rand%0d: desired=%0d cycles=%0d pos=%0d busy=%0d", k, des, rc, pos, busy);
    end
    run_idle("rand_final", 300);
    chk("rand_final_pos", 16'(pos), 16'(des));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
